// File: rtl/async_fifo_rptr_gray.sv
// Read-side pointer/status for the dual-clock FIFO; optional sticky underflow via FIFO_RPTR_UNDERFLOW_EN.
// Latency: pointer/flags/level registered one rclk after rinc or rq2_wptr; raddr is a direct register output.
// Backpressure: rinc is ignored while rempty=1, so reads never pass the synchronised write pointer.
module async_fifo_rptr_gray #(
  parameter int ADDR_W    = 4,
  parameter int AE_THRESH = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rinc,
  input  logic [ADDR_W:0]   rq2_wptr,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rlevel,
  output logic              runderflow
);

  localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] rgray_next;
  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] level_next;
  logic            rd;

  assign rd         = rinc & ~rempty;
  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin         = '0;
    wbin[ADDR_W] = rq2_wptr[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
  end

  assign level_next = wbin - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_LIM);
    end
  end

  assign raddr = rbin[ADDR_W-1:0];

`ifdef FIFO_RPTR_UNDERFLOW_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end
  end
`else
  assign runderflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rptr_gray.sv
// Bench for async_fifo_rptr_gray (ADDR_W=4, AE_THRESH=2): per-edge expectations queued at drive time, popped after the edge.
module tb_async_fifo_rptr_gray;

  typedef struct {
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       empty;
    logic       ae;
    logic [4:0] level;
    logic       uf;
  } exp_t;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  int   m_rbin;
  int   m_level;
  bit   m_empty;
  bit   m_uf;

  async_fifo_rptr_gray #(.ADDR_W(4), .AE_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus at posedge+1, model it, then compare after the next edge.
  task automatic step(input bit inc, input int wbin);
    exp_t e;
    exp_t o;
    bit   rd;
    rinc     = inc;
    rq2_wptr = gray(wbin);
    rd       = inc && !m_empty;
`ifdef FIFO_RPTR_UNDERFLOW_EN
    if (inc && m_empty) m_uf = 1'b1;
`endif
    m_rbin  = (m_rbin + (rd ? 1 : 0)) % 32;
    m_level = ((wbin % 32) - m_rbin + 32) % 32;
    m_empty = (m_level == 0);
    e.rptr  = gray(m_rbin);
    e.raddr = 4'(m_rbin % 16);
    e.empty = m_empty;
    e.ae    = (m_level <= 2);
    e.level = 5'(m_level);
    e.uf    = m_uf;
    sb.push_back(e);
    @(posedge rclk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underrun", 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      chk("rptr",   32'(rptr),          32'(o.rptr));
      chk("raddr",  32'(raddr),         32'(o.raddr));
      chk("rempty", 32'(rempty),        32'(o.empty));
      chk("ralmst", 32'(ralmost_empty), 32'(o.ae));
      chk("rlevel", 32'(rlevel),        32'(o.level));
      chk("runder", 32'(runderflow),    32'(o.uf));
    end
  endtask

  // Assert reset mid-clock with a read pending, check immediate values, release and idle 3 cycles.
  task automatic apply_reset();
    #3;
    rrst_n = 1'b0;
    rinc   = 1'b1;
    #1;
    chk("rst_rptr",   32'(rptr),          32'd0);
    chk("rst_raddr",  32'(raddr),         32'd0);
    chk("rst_rempty", 32'(rempty),        32'd1);
    chk("rst_ralmst", 32'(ralmost_empty), 32'd1);
    chk("rst_rlevel", 32'(rlevel),        32'd0);
    chk("rst_runder", 32'(runderflow),    32'd0);
    @(posedge rclk);
    #1;
    rrst_n   = 1'b1;
    rinc     = 1'b0;
    rq2_wptr = 5'd0;
    m_rbin   = 0;
    m_level  = 0;
    m_empty  = 1'b1;
    m_uf     = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] prev_ptr;
    logic [3:0] prev_addr;
    logic [4:0] diff;
    int         addr_wraps;
    bit         saw_msb_wrap;

    rrst_n   = 1'b0;
    rinc     = 1'b0;
    rq2_wptr = 5'd0;
    m_rbin   = 0;
    m_level  = 0;
    m_empty  = 1'b1;
    m_uf     = 1'b0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    step(1'b0, 2);
    step(1'b1, 2);
    apply_reset();

    // Fill to 3, drain through empty, then keep requesting on an empty FIFO.
    step(1'b0, 3);
    for (int i = 0; i < 3; i++) step(1'b1, 3);
    chk("drain_rptr", 32'(rptr), 32'h02);
    for (int i = 0; i < 7; i++) step(1'b1, 3);
    chk("guard_raddr", 32'(raddr), 32'd3);

    // Wrap: 8 ahead, 40 reads with the writer advancing in lockstep.
    apply_reset();
    step(1'b0, 8);
    addr_wraps   = 0;
    saw_msb_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev_ptr  = rptr;
      prev_addr = raddr;
      step(1'b1, (m_rbin + 9) % 32);
      diff = prev_ptr ^ rptr;
      chk("gray_1bit", 32'($countones(diff)), 32'd1);
      if (prev_addr == 4'd15 && raddr == 4'd0) addr_wraps++;
      if (prev_ptr == 5'b10000 && rptr == 5'b00000) saw_msb_wrap = 1'b1;
    end
    chk("raddr_wraps", 32'(addr_wraps), 32'd2);
    chk("rptr_msb_wrap", 32'(saw_msb_wrap), 32'd1);

    // Simultaneous read and write-pointer advance at level 1.
    step(1'b0, 9);
    chk("lvl1", 32'(rlevel), 32'd1);
    step(1'b1, 10);
    chk("simul_level", 32'(rlevel), 32'd1);
    chk("simul_empty", 32'(rempty), 32'd0);

    // Full level from rbin=0.
    apply_reset();
    step(1'b0, 16);
    chk("full_level", 32'(rlevel), 32'd16);
    step(1'b1, 16);
    step(1'b1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
